// File: rtl/fifo_wr_arbiter_pkg.sv
// Shared FIFO definitions: arbiter FSM encoding, default word width and stats counter width.
package fifo_wr_arbiter_pkg;

   typedef enum logic {
      IDLE  = 1'b0,
      GRANT = 1'b1
   } arb_state_e;

   localparam int unsigned FIFO_DATASIZE = 32;
   localparam int unsigned STAT_W        = 16;

endpackage

// File: rtl/fifo_wr_arbiter_picker.sv
// Round-robin picker: first set request at or after rr_ptr, wrapping NREQ-1 -> 0.
module fifo_rr_picker #(
   parameter int unsigned NREQ = 4,
   parameter int unsigned IDW  = 2
) (
   input  logic [NREQ-1:0] req,
   input  logic [IDW-1:0]  rr_ptr,
   output logic            found,
   output logic [IDW-1:0]  sel
);

   logic [2*NREQ-1:0] dbl;
   logic [NREQ-1:0]   rot;
   logic              hit;
   int unsigned       off;
   int unsigned       sum;

   // Shifting a doubled vector rotates rr_ptr down to bit 0; lowest set bit wins.
   always_comb begin
      dbl = {req, req} >> rr_ptr;
      rot = dbl[NREQ-1:0];
      hit = 1'b0;
      off = 0;
      for (int unsigned i = 0; i < NREQ; i++) begin
         if (rot[i] && !hit) begin
            hit = 1'b1;
            off = i;
         end
      end
      sum = 32'(rr_ptr) + off;
      if (sum >= NREQ) sum = sum - NREQ;
      found = hit;
      sel   = IDW'(sum);
   end

endmodule

// File: rtl/fifo_wr_arbiter.sv
// Round-robin arbiter sharing the FIFO write port among NREQ requesters.
// Define FIFO_ARB_STATS_EN to add per-requester saturating accepted-word counters.
module fifo_wr_arbiter
   import fifo_wr_arbiter_pkg::*;
#(
   parameter  int unsigned DATASIZE  = FIFO_DATASIZE,
   parameter  int unsigned NREQ      = 4,
   parameter  int unsigned MAX_BURST = 8,
   localparam int unsigned IDW       = $clog2(NREQ)
) (
   input  logic                     wclk,
   input  logic                     wrst,
   input  logic [NREQ-1:0]          req_valid,
   input  logic [NREQ-1:0]          req_last,
   input  logic [NREQ*DATASIZE-1:0] req_data,
   output logic [NREQ-1:0]          req_ready,
   input  logic                     wfull,
   output logic [DATASIZE-1:0]      wdata,
   output logic                     wclken,
   output logic [IDW-1:0]           grant_id,
`ifdef FIFO_ARB_STATS_EN
   input  logic [IDW-1:0]           stat_sel,
   output logic [STAT_W-1:0]        stat_count,
`endif
   output logic                     busy
);

   arb_state_e      state, state_next;
   logic [IDW-1:0]  rr_ptr;
   logic [IDW-1:0]  pick;
   logic            found;
   logic [7:0]      beat_cnt;
   logic            xfer;
   logic            done;

   fifo_rr_picker #(
      .NREQ (NREQ),
      .IDW  (IDW)
   ) u_picker (
      .req    (req_valid),
      .rr_ptr (rr_ptr),
      .found  (found),
      .sel    (pick)
   );

   assign done = xfer & (req_last[grant_id] | (beat_cnt == 8'(MAX_BURST - 1)));

   always_ff @(posedge wclk or posedge wrst) begin
      if (wrst) begin
         state    <= IDLE;
         grant_id <= '0;
         rr_ptr   <= '0;
         beat_cnt <= '0;
      end else begin
         state <= state_next;
         if (state == IDLE && found) begin
            grant_id <= pick;
            beat_cnt <= '0;
         end
         if (xfer) beat_cnt <= beat_cnt + 8'd1;
         if (done) rr_ptr <= (grant_id == IDW'(NREQ - 1)) ? '0 : grant_id + IDW'(1);
      end
   end

   always_comb begin
      state_next = state;
      case (state)
         IDLE:    if (found) state_next = GRANT;
         GRANT:   if (done)  state_next = IDLE;
         default: state_next = IDLE;
      endcase
   end

   always_comb begin
      busy      = 1'b0;
      xfer      = 1'b0;
      wclken    = 1'b0;
      req_ready = '0;
      wdata     = '0;
      if (state == GRANT) begin
         busy                = 1'b1;
         req_ready[grant_id] = ~wfull;
         xfer                = req_valid[grant_id] & ~wfull;
         wclken              = xfer;
         wdata               = req_data[32'(grant_id)*DATASIZE +: DATASIZE];
      end
   end

`ifdef FIFO_ARB_STATS_EN
   logic [STAT_W-1:0] stat_cnt [NREQ];

   always_ff @(posedge wclk or posedge wrst) begin
      if (wrst) begin
         for (int unsigned i = 0; i < NREQ; i++) stat_cnt[i] <= '0;
      end else if (xfer && stat_cnt[grant_id] != '1) begin
         stat_cnt[grant_id] <= stat_cnt[grant_id] + STAT_W'(1);
      end
   end

   assign stat_count = (32'(stat_sel) < NREQ) ? stat_cnt[stat_sel] : '0;
`endif

endmodule
